// File: rtl/data_source_mc.sv
// data_source_mc: loadable sample memory replayed over a valid/ready stream.
// Supports inter-word gaps, channel tagging, first/last markers, single or
// repeat passes, and a sticky error flag for illegal requests.
module data_source_mc #(
  parameter int WIDTH    = 32,
  parameter int MWIDTH   = 1,
  parameter int N_DATA   = 64,
  parameter int LOGNDATA = 6,
  parameter int N_CHAN   = 2,
  parameter int LOGNCHAN = 1,
  parameter int GAPWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_nd,
  input  logic [LOGNDATA-1:0] load_addr,
  input  logic [WIDTH-1:0]    load_data,
  input  logic [MWIDTH-1:0]   load_m,
  input  logic                start,
  input  logic                stop,
  input  logic                repeat_mode,
  input  logic [GAPWIDTH-1:0] gap,
  input  logic [LOGNDATA:0]   n_samples,
  input  logic                out_ready,
  output logic                out_nd,
  output logic [WIDTH-1:0]    out_data,
  output logic [MWIDTH-1:0]   out_m,
  output logic [LOGNCHAN-1:0] out_chan,
  output logic                first,
  output logic                last,
  output logic                busy,
  output logic                error
);

  typedef struct packed {
    logic [MWIDTH-1:0] m;
    logic [WIDTH-1:0]  d;
  } word_t;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

  localparam logic [LOGNDATA:0]   N_MAX   = (LOGNDATA+1)'(N_DATA);
  localparam logic [LOGNDATA:0]   CMASK_N = (LOGNDATA+1)'(N_CHAN-1);
  localparam logic [LOGNDATA-1:0] CMASK_A = LOGNDATA'(N_CHAN-1);

  word_t               mem [N_DATA];
  state_t              state, state_nxt;
  logic                cfg_rep;
  logic [GAPWIDTH-1:0] cfg_gap, gap_cnt;
  logic [LOGNDATA:0]   cfg_n;
  logic [LOGNDATA-1:0] addr, rd_addr;
  logic                stop_flag;
  logic                idle, xfer, n_ok, load_ok, start_ok, stop_now, rd_en, err_set;

  assign idle     = (state == IDLE);
  assign xfer     = (state == SEND) && out_ready;
  // n_samples must be 1..N_DATA and a whole number of channel groups
  assign n_ok     = (n_samples != '0) && (n_samples <= N_MAX) &&
                    ((n_samples & CMASK_N) == '0);
  assign load_ok  = idle && load_nd;
  // a load in the same cycle wins; the start is dropped and flagged
  assign start_ok = idle && start && !load_nd && n_ok;
  assign stop_now = cfg_rep && (stop || stop_flag);
  assign err_set  = (start && (!idle || load_nd || !n_ok)) || (load_nd && !idle);
  // the memory is read on entry to SEND: from FETCH (word 0) or on every transfer
  assign rd_en    = (state == FETCH) || xfer;
  assign rd_addr  = (state == FETCH) ? addr : (last ? '0 : addr + 1'b1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = FETCH;
      FETCH: state_nxt = SEND;
      SEND: begin
        if (xfer) begin
          if (stop_now || (last && !cfg_rep)) state_nxt = IDLE;
          else if (cfg_gap == '0)             state_nxt = SEND;
          else                                state_nxt = GAP;
        end
      end
      GAP: begin
        if (stop_now)          state_nxt = IDLE;
        else if (gap_cnt <= 1) state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_nd = (state == SEND);
    busy   = !idle;
  end

  // sample memory: no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (load_ok) mem[load_addr] <= {load_m, load_data};
  end

  // playback config, address, gap counter and pending-stop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rep   <= 1'b0;
      cfg_gap   <= '0;
      cfg_n     <= '0;
      addr      <= '0;
      gap_cnt   <= '0;
      stop_flag <= 1'b0;
    end else begin
      if (start_ok) begin
        cfg_rep <= repeat_mode;
        cfg_gap <= gap;
        cfg_n   <= n_samples;
        addr    <= '0;
      end
      if (rd_en) addr <= rd_addr;
      if (xfer)                gap_cnt <= cfg_gap;
      else if (state == GAP)   gap_cnt <= gap_cnt - 1'b1;
      if (state_nxt == IDLE)             stop_flag <= 1'b0;
      else if (!idle && stop && cfg_rep) stop_flag <= 1'b1;
    end
  end

  // registered memory read into the output word and its tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_m    <= '0;
      out_chan <= '0;
      first    <= 1'b0;
      last     <= 1'b0;
    end else if (rd_en) begin
      out_data <= mem[rd_addr].d;
      out_m    <= mem[rd_addr].m;
      out_chan <= LOGNCHAN'(rd_addr & CMASK_A);
      first    <= (rd_addr == '0);
      last     <= ({1'b0, rd_addr} == (cfg_n - 1'b1));
    end
  end

  // sticky error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       error <= 1'b0;
    else if (err_set) error <= 1'b1;
  end

endmodule

// File: tb/tb_data_source_mc.sv
// Self-checking bench for data_source_mc: scoreboard of expected words plus
// per-scenario timing and flag checks.
module tb_data_source_mc;

  logic        clk, rst_n;
  logic        load_nd, start, stop, repeat_mode, out_ready;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic [0:0]  load_m;
  logic [7:0]  gap;
  logic [6:0]  n_samples;
  logic        out_nd, first, last, busy, error;
  logic [31:0] out_data;
  logic [0:0]  out_m;
  logic [0:0]  out_chan;

  data_source_mc dut (
    .clk(clk), .rst_n(rst_n), .load_nd(load_nd), .load_addr(load_addr),
    .load_data(load_data), .load_m(load_m), .start(start), .stop(stop),
    .repeat_mode(repeat_mode), .gap(gap), .n_samples(n_samples),
    .out_ready(out_ready), .out_nd(out_nd), .out_data(out_data), .out_m(out_m),
    .out_chan(out_chan), .first(first), .last(last), .busy(busy), .error(error)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        m;
    logic        c;
    logic        f;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_d [64];
  logic        model_m [64];
  int          n_checks = 0;
  int          n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every accepted word is compared with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_nd && out_ready) begin
      exp_t e, a;
      a = {out_data, out_m[0], out_chan[0], first, last};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got data=%0d m=%0d chan=%0d first=%0d last=%0d, required no word",
                 a.d, a.m, a.c, a.f, a.l);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard_word: got data=%0d m=%0d chan=%0d first=%0d last=%0d, required data=%0d m=%0d chan=%0d first=%0d last=%0d",
                   a.d, a.m, a.c, a.f, a.l, e.d, e.m, e.c, e.f, e.l);
        end
      end
    end
  end

  task automatic push_words(input int n, input int count, input int a0);
    for (int i = 0; i < count; i++) begin
      int a;
      a = (a0 + i) % n;
      sb.push_back({model_d[a], model_m[a], 1'(a % 2), a == 0, a == n - 1});
    end
  endtask

  task automatic load_word(input int a, input logic [31:0] d, input logic m);
    load_nd = 1'b1; load_addr = 6'(a); load_data = d; load_m = m;
    model_d[a] = d; model_m[a] = m;
    @(posedge clk); #1;
    load_nd = 1'b0;
  endtask

  task automatic do_start(input int n, input int g, input bit rep);
    n_samples = 7'(n); gap = 8'(g); repeat_mode = rep; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [39:0] act;
    act = {out_nd, busy, error, first, last, out_data, out_m, out_chan};
    n_checks++;
    if (act !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", act);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) load_word(i, 32'(100 + i), 1'(i & 1));
    n_checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_load: busy=%0b error=%0b, required 0 0", busy, error);
    end
  endtask

  task automatic test_single();
    push_words(8, 8, 0);
    do_start(8, 0, 0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_nd !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cycle1: busy=%0b out_nd=%0b, required 1 0", busy, out_nd);
    end
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_nd !== 1'b1) begin
        n_fail++;
        $display("FAIL single_out_nd: cycle %0d got %0b, required 1", c, out_nd);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_nd !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_end: busy=%0b out_nd=%0b pending=%0d, required 0 0 0", busy, out_nd, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gap();
    bit          held, done;
    logic [31:0] held_d;
    int          last_x, nx;
    held = 0; done = 0; last_x = -1; nx = 0; held_d = '0;
    push_words(8, 8, 0);
    do_start(8, 3, 0);
    for (int c = 2; c < 300; c++) begin
      @(posedge clk); #1;
      out_ready = ((c / 2) % 2 == 0);
      @(negedge clk);
      if (held) begin
        n_checks++;
        if (out_nd !== 1'b1 || out_data !== held_d) begin
          n_fail++;
          $display("FAIL gap_hold: cycle %0d out_nd=%0b data=%0d, required 1 %0d", c, out_nd, out_data, held_d);
        end
      end
      held   = out_nd && !out_ready;
      held_d = out_data;
      if (out_nd && out_ready) begin
        if (last_x >= 0) begin
          n_checks++;
          if (c - last_x < 4) begin
            n_fail++;
            $display("FAIL gap_spacing: transfers %0d cycles apart, required >= 4", c - last_x);
          end
        end
        last_x = c;
        nx++;
      end
      if (!busy) begin done = 1; break; end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n_checks++;
    if (!done || nx != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL gap_complete: done=%0b transfers=%0d pending=%0d, required 1 8 0", done, nx, sb.size());
    end
  endtask

  task automatic test_repeat();
    push_words(4, 7, 0);
    do_start(4, 0, 1);
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      stop = (c == 8);
    end
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_nd !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL repeat_stop: busy=%0b out_nd=%0b pending=%0d, required 0 0 0", busy, out_nd, sb.size());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_idle: busy=%0b error=%0b, required 0 0", busy, error);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_cfg();
    int bad [3] = '{0, 3, 65};
    foreach (bad[k]) begin
      do_reset();
      do_start(bad[k], 0, 0);
      @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_cfg_n%0d: error=%0b busy=%0b, required 1 0", bad[k], error, busy);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        n_checks++;
        if (out_nd !== 1'b0) begin
          n_fail++;
          $display("FAIL bad_cfg_out_nd: n=%0d got %0b, required 0", bad[k], out_nd);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_err();
    bit to;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      push_words(8, 8, 0);
      do_start(8, 0, 0);
      for (int c = 2; c <= 4; c++) begin
        @(posedge clk); #1;
        start = (ph == 0 && c == 3); n_samples = 7'd4;
        load_nd = (ph == 1 && c == 3); load_addr = 6'd5; load_data = 32'd999;
      end
      start = 1'b0; load_nd = 1'b0;
      @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_err_ph%0d: error=%0b busy=%0b, required 1 1", ph, error, busy);
      end
      run_until_idle(40, to);
      n_checks++;
      if (to || sb.size() != 0) begin
        n_fail++;
        $display("FAIL busy_err_seq_ph%0d: timeout=%0b pending=%0d, required 0 0", ph, to, sb.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit          to;
    logic [39:0] act;
    push_words(8, 8, 0);
    do_start(8, 2, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    act = {out_nd, busy, error, first, last, out_data, out_m, out_chan};
    n_checks++;
    if (act !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0", act);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_nd !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet: out_nd=%0b busy=%0b, required 0 0", out_nd, busy);
      end
    end
    @(posedge clk); #1;
    push_words(8, 8, 0);
    do_start(8, 0, 0);
    run_until_idle(40, to);
    n_checks++;
    if (to || sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_replay: timeout=%0b pending=%0d, required 0 0", to, sb.size());
    end
  endtask

  task automatic test_full();
    bit to;
    push_words(64, 64, 0);
    do_start(64, 0, 0);
    run_until_idle(100, to);
    n_checks++;
    if (to || sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_depth: timeout=%0b pending=%0d, required 0 0", to, sb.size());
    end
  endtask

  task automatic test_load_start();
    bit to;
    do_reset();
    n_samples = 7'd10; gap = 8'd0; repeat_mode = 1'b0; start = 1'b1;
    load_word(8, 32'd777, 1'b0);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_start_err: error=%0b busy=%0b, required 1 0", error, busy);
    end
    @(posedge clk); #1;
    push_words(10, 10, 0);
    do_start(10, 0, 0);
    run_until_idle(40, to);
    n_checks++;
    if (to || sb.size() != 0) begin
      n_fail++;
      $display("FAIL load_start_play: timeout=%0b pending=%0d, required 0 0", to, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; load_nd = 1'b0; start = 1'b0; stop = 1'b0; repeat_mode = 1'b0;
    out_ready = 1'b1; load_addr = '0; load_data = '0; load_m = '0; gap = '0; n_samples = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_gap();
    test_repeat();
    test_bad_cfg();
    test_busy_err();
    test_reset_mid();
    test_full();
    test_load_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_source_mc.md
# data_source_mc

Parametrised, multi-channel successor to the test data source. The block holds a loadable sample memory and plays it back over a valid/ready stream, with optional inter-sample gaps, channel tagging, first/last markers, single-shot or repeat mode, and a sticky error flag. It sits at the head of a DSP chain in simulation and on-chip test benches, feeding `out_*` into the unit under test.

## Interface
- WIDTH, 32, sample data width
- MWIDTH, 1, per-sample metadata width
- N_DATA, 64, sample memory depth (power of two)
- LOGNDATA, 6, log2(N_DATA)
- N_CHAN, 2, interleaved channel count (power of two, ≤ N_DATA)
- LOGNCHAN, 1, log2(N_CHAN), minimum 1
- GAPWIDTH, 8, width of gap count
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_nd  in  1  write strobe for sample memory
- load_addr  in  LOGNDATA  write address
- load_data  in  WIDTH  write data
- load_m  in  MWIDTH  write metadata
- start  in  1  begin playback (single-cycle pulse)
- stop  in  1  end repeat playback (single-cycle pulse)
- repeat_mode  in  1  1 = loop, 0 = single pass; sampled with start
- gap  in  GAPWIDTH  idle cycles between words; sampled with start
- n_samples  in  LOGNDATA+1  words per pass, 1..N_DATA, multiple of N_CHAN; sampled with start
- out_ready  in  1  downstream accept
- out_nd  out  1  out_data/out_m/out_chan/first/last valid
- out_data  out  WIDTH  sample
- out_m  out  MWIDTH  metadata
- out_chan  out  LOGNCHAN  channel = address mod N_CHAN
- first  out  1  word is address 0 of a pass
- last  out  1  word is address n_samples-1 of a pass
- busy  out  1  playback active
- error  out  1  sticky error, cleared only by reset

## Operation
- States: IDLE, FETCH, SEND, GAP.
- IDLE: load_nd writes memory[load_addr] = {load_m, load_data}. start with valid config latches repeat_mode, gap, n_samples; address = 0; → FETCH; busy = 1.
- FETCH: registered memory read of current address → SEND.
- SEND: out_nd = 1; all out_* held stable until out_nd & out_ready. On transfer: address advances (wraps to 0 after n_samples-1); → SEND again if gap = 0, else → GAP with counter = gap.
- GAP: out_nd = 0; counter decrements each cycle; at 1 → SEND with next word already read.
- End of pass (transfer with last = 1): single mode → IDLE, busy = 0; repeat mode → continue at address 0, first = 1 again.
- stop in repeat mode: recorded; playback ends after the next accepted transfer (if stop occurs in SEND) or immediately (if in GAP), → IDLE. stop in IDLE or single mode: ignored, no error.
- Error (sticky, error = 1 next cycle; offending action ignored): start while busy; load_nd while busy; start with n_samples = 0, > N_DATA, or not a multiple of N_CHAN; start and load_nd in the same cycle (load performed, start ignored).
- Memory is not reset; contents survive rst_n.

## Timing
- Reset (asynchronous): state IDLE, out_nd/out_data/out_m/out_chan/first/last/busy/error = 0, latched config = 0, stop flag cleared. Reset mid-playback aborts with no further out_nd.
- start high in cycle 0 → busy = 1 in cycle 1, out_nd = 1 in cycle 2 with address 0.
- Transfer in cycle k, gap = G → next out_nd in cycle k+1+G (G = 0 gives back-to-back).
- out_ready low: out_nd and data held indefinitely; gap counting does not begin until transfer.
- Last transfer of single pass in cycle k → busy = 0, out_nd = 0 in cycle k+1; a new start is accepted in cycle k+1.
- Load write visible to playback started the following cycle or later.

## Test plan
- Load 0..7 with data 100+i, m = i&1; start n_samples=8, gap=0, out_ready=1 → out_nd cycles 2–9, data 100..107, out_chan 0,1,0,1…, first only on 100, last only on 107, busy low in cycle 10.
- Same load, gap=3, out_ready toggled 1/0 every 2 cycles → each word held while out_ready=0, ≥3 idle cycles between transfers, sequence unchanged.
- repeat_mode=1, n_samples=4, stop pulsed during third word of pass 2 → words 100..103,100..102, first twice, last once, then IDLE.
- start with n_samples=0, then n_samples=3 (N_CHAN=2) → error = 1, busy stays 0, no out_nd.
- start during playback and load_nd during playback → error = 1, playback sequence and memory unchanged.
- rst_n low mid-playback for 1 cycle → all outputs 0 immediately; restart replays preloaded memory correctly.
